// File: rtl/ref_cache_tag_update_pkg.sv
// Shared constants and types for the reference-cache tag update block.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional macro REF_CACHE_PLRU_EN selects tree pseudo-LRU replacement.
package ref_cache_tag_update_pkg;

    localparam int C_N_WAY       = 3;   // log2 of associativity
    localparam int TAG_ADDR_WDTH = 20;
    localparam int C_N_SET_BITS  = 5;   // log2 of set count

    localparam int N_WAYS = 1 << C_N_WAY;
    localparam int N_SETS = 1 << C_N_SET_BITS;

    // Tree pseudo-LRU needs one node bit per internal node of the way tree
    localparam int PLRU_W = N_WAYS - 1;

`ifdef REF_CACHE_PLRU_EN
    localparam bit PLRU_EN = 1'b1;
`else
    localparam bit PLRU_EN = 1'b0;
`endif

    // Per-set replacement state: tree bits, or a round-robin way pointer
    localparam int REPL_W = PLRU_EN ? PLRU_W : C_N_WAY;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL_REQ  = 2'd1,
        ST_FILL_WAIT = 2'd2,
        ST_TAG_WR    = 2'd3
    } state_e;

    typedef logic [N_WAYS-1:0] way_mask_t;
    typedef logic [REPL_W-1:0] repl_t;

endpackage

// File: rtl/ref_cache_victim_sel.sv
// Victim way selection and replacement-state update for one set (purely combinational).
// Latency: 0 cycles.
// Backpressure: none; REF_CACHE_PLRU_EN selects tree pseudo-LRU, otherwise round-robin pointer.
module ref_cache_victim_sel
    import ref_cache_tag_update_pkg::*;
(
    input  logic [N_WAYS-1:0]  valid_bits,
    input  logic [REPL_W-1:0]  repl_state,
    input  logic [C_N_WAY-1:0] acc_way,
    input  logic               acc_is_fill,
    output logic [C_N_WAY-1:0] victim_way,
    output logic               set_full,
    output logic [REPL_W-1:0]  repl_next
);

    logic [C_N_WAY-1:0] policy_way;
    logic [C_N_WAY-1:0] first_inv;

    // Lowest-index invalid way; the policy way is only used once the set is full
    always_comb begin
        first_inv = '0;
        for (int i = N_WAYS - 1; i >= 0; i--) begin
            if (!valid_bits[i]) begin
                first_inv = C_N_WAY'(i);
            end
        end
        set_full   = &valid_bits;
        victim_way = set_full ? policy_way : first_inv;
    end

`ifdef REF_CACHE_PLRU_EN
    // Tree layout: bit0 root, bits[2:1] second level, bits[6:3] leaf pairs.
    // A 0 bit steers the victim to the lower half below that node.
    logic [1:0] mids;
    logic [3:0] leaves;
    logic [1:0] mids_n;
    logic [3:0] leaves_n;
    logic       unused_acc_is_fill;

    assign unused_acc_is_fill = acc_is_fill;

    // Walk the tree for the victim, and point every node on the accessed path away from it
    always_comb begin
        mids     = repl_state[2:1];
        leaves   = repl_state[6:3];
        policy_way[2] = repl_state[0];
        policy_way[1] = mids[policy_way[2]];
        policy_way[0] = leaves[policy_way[2:1]];

        mids_n   = mids;
        leaves_n = leaves;
        mids_n[acc_way[2]]     = ~acc_way[1];
        leaves_n[acc_way[2:1]] = ~acc_way[0];
        repl_next = {leaves_n, mids_n, ~acc_way[2]};
    end
`else
    logic [C_N_WAY-1:0] unused_acc_way;

    assign unused_acc_way = acc_way;

    // Round-robin: pointer advances only when a fill evicts from a full set
    always_comb begin
        policy_way = repl_state;
        repl_next  = (acc_is_fill && set_full) ? repl_state + REPL_W'(1) : repl_state;
    end
`endif

endmodule

// File: rtl/ref_cache_tag_update.sv
// Write side of the reference-cache tag store: hit bookkeeping, miss fill sequencing, valid bits.
// Latency: hit resp 1 cycle after accept; miss resp 3 cycles + fill_req_ready wait + fill_done wait.
// Backpressure: lkp_ready only in IDLE with no invalidate pending; fill request held until fill_req_ready.
// Optional macro REF_CACHE_PLRU_EN switches replacement from round-robin to tree pseudo-LRU.
module ref_cache_tag_update
    import ref_cache_tag_update_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     lkp_valid,
    output logic                     lkp_ready,
    input  logic [C_N_SET_BITS-1:0]  lkp_set,
    input  logic [TAG_ADDR_WDTH-1:0] lkp_tag,
    input  logic                     cmp_ishit,
    input  logic [C_N_WAY-1:0]       cmp_set_idx,
    output logic [N_WAYS-1:0]        valid_bits_out,
    input  logic                     inv_all,
    output logic                     fill_req_valid,
    input  logic                     fill_req_ready,
    output logic [C_N_SET_BITS-1:0]  fill_req_set,
    output logic [C_N_WAY-1:0]       fill_req_way,
    output logic [TAG_ADDR_WDTH-1:0] fill_req_tag,
    input  logic                     fill_done,
    output logic                     tag_wr_en,
    output logic [C_N_SET_BITS-1:0]  tag_wr_set,
    output logic [C_N_WAY-1:0]       tag_wr_way,
    output logic [TAG_ADDR_WDTH-1:0] tag_wr_tag,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [C_N_WAY-1:0]       resp_way
);

    state_e                     state_q, state_d;
    logic [C_N_SET_BITS-1:0]    set_q, set_d;
    logic [TAG_ADDR_WDTH-1:0]   tag_q, tag_d;
    logic [C_N_WAY-1:0]         way_q, way_d;
    logic                       hit_resp_q, hit_resp_d;
    logic                       pend_q, pend_d;
    way_mask_t                  valid_q [N_SETS];
    way_mask_t                  valid_d [N_SETS];
    repl_t                      repl_q  [N_SETS];
    repl_t                      repl_d  [N_SETS];

    logic [C_N_SET_BITS-1:0]    sel_set;
    logic                       in_tag_wr;
    logic                       lkp_acc;
    logic [C_N_WAY-1:0]         vs_victim;
    logic                       vs_full;
    repl_t                      vs_repl_next;

    // Accept and tag write never share a cycle, so one selector serves both
    assign in_tag_wr = (state_q == ST_TAG_WR);
    assign sel_set   = in_tag_wr ? set_q : lkp_set;

    ref_cache_victim_sel u_victim_sel (
        .valid_bits  (valid_q[sel_set]),
        .repl_state  (repl_q[sel_set]),
        .acc_way     (in_tag_wr ? way_q : cmp_set_idx),
        .acc_is_fill (in_tag_wr),
        .victim_way  (vs_victim),
        .set_full    (vs_full),
        .repl_next   (vs_repl_next)
    );

    // An invalidate (new or pending) blocks lookups until it has been applied
    assign lkp_ready = !reset && (state_q == ST_IDLE) && !inv_all && !pend_q;
    assign lkp_acc   = lkp_valid && lkp_ready;

    // A pending invalidate hides the line just filled so the comparator never hits on it
    assign valid_bits_out = pend_q ? '0 : valid_q[lkp_set];

    assign fill_req_valid = (state_q == ST_FILL_REQ);
    assign fill_req_set   = set_q;
    assign fill_req_way   = way_q;
    assign fill_req_tag   = tag_q;

    assign tag_wr_en  = in_tag_wr;
    assign tag_wr_set = set_q;
    assign tag_wr_way = way_q;
    assign tag_wr_tag = tag_q;

    assign resp_valid = hit_resp_q || in_tag_wr;
    assign resp_hit   = hit_resp_q;
    assign resp_way   = way_q;

    // Next-state, capture and valid/replacement updates
    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        tag_d      = tag_q;
        way_d      = way_q;
        hit_resp_d = 1'b0;
        pend_d     = pend_q;
        valid_d    = valid_q;
        repl_d     = repl_q;

        unique case (state_q)
            ST_IDLE: begin
                if (inv_all || pend_q) begin
                    valid_d = '{default: '0};
                    repl_d  = '{default: '0};
                    pend_d  = 1'b0;
                end else if (lkp_acc) begin
                    set_d = lkp_set;
                    tag_d = lkp_tag;
                    if (cmp_ishit) begin
                        way_d           = cmp_set_idx;
                        hit_resp_d      = 1'b1;
                        repl_d[lkp_set] = vs_repl_next;
                    end else begin
                        way_d   = vs_victim;
                        state_d = ST_FILL_REQ;
                    end
                end
            end
            ST_FILL_REQ: begin
                if (fill_req_ready) begin
                    state_d = ST_FILL_WAIT;
                end
            end
            ST_FILL_WAIT: begin
                if (fill_done) begin
                    state_d = ST_TAG_WR;
                end
            end
            ST_TAG_WR: begin
                valid_d[set_q][way_q] = 1'b1;
                repl_d[set_q]         = vs_repl_next;
                state_d               = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Invalidate arriving mid-miss is remembered and applied back in IDLE
        if (inv_all && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end
    end

    // State registers with synchronous reset; reset aborts any miss in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            set_q      <= '0;
            tag_q      <= '0;
            way_q      <= '0;
            hit_resp_q <= 1'b0;
            pend_q     <= 1'b0;
            valid_q    <= '{default: '0};
            repl_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            tag_q      <= tag_d;
            way_q      <= way_d;
            hit_resp_q <= hit_resp_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            repl_q     <= repl_d;
        end
    end

    // Vacuous use of vs_full keeps the selector port visible to the top for readability
    logic unused_vs_full;
    assign unused_vs_full = vs_full;

endmodule

// File: tb/tb_ref_cache_tag_update.sv
// Self-checking bench for ref_cache_tag_update against a behavioural cache model.
// Latency: checks hit/miss response timing cycle-exactly.
// Backpressure: exercises fill_req_ready stalls, fill_done delays, inv_all and reset mid-miss.
module tb_ref_cache_tag_update;
    import ref_cache_tag_update_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     lkp_valid;
    logic                     lkp_ready;
    logic [C_N_SET_BITS-1:0]  lkp_set;
    logic [TAG_ADDR_WDTH-1:0] lkp_tag;
    logic                     cmp_ishit;
    logic [C_N_WAY-1:0]       cmp_set_idx;
    logic [N_WAYS-1:0]        valid_bits_out;
    logic                     inv_all;
    logic                     fill_req_valid;
    logic                     fill_req_ready;
    logic [C_N_SET_BITS-1:0]  fill_req_set;
    logic [C_N_WAY-1:0]       fill_req_way;
    logic [TAG_ADDR_WDTH-1:0] fill_req_tag;
    logic                     fill_done;
    logic                     tag_wr_en;
    logic [C_N_SET_BITS-1:0]  tag_wr_set;
    logic [C_N_WAY-1:0]       tag_wr_way;
    logic [TAG_ADDR_WDTH-1:0] tag_wr_tag;
    logic                     resp_valid;
    logic                     resp_hit;
    logic [C_N_WAY-1:0]       resp_way;

    always #5 clk = ~clk;

    ref_cache_tag_update dut (
        .clk            (clk),
        .reset          (reset),
        .lkp_valid      (lkp_valid),
        .lkp_ready      (lkp_ready),
        .lkp_set        (lkp_set),
        .lkp_tag        (lkp_tag),
        .cmp_ishit      (cmp_ishit),
        .cmp_set_idx    (cmp_set_idx),
        .valid_bits_out (valid_bits_out),
        .inv_all        (inv_all),
        .fill_req_valid (fill_req_valid),
        .fill_req_ready (fill_req_ready),
        .fill_req_set   (fill_req_set),
        .fill_req_way   (fill_req_way),
        .fill_req_tag   (fill_req_tag),
        .fill_done      (fill_done),
        .tag_wr_en      (tag_wr_en),
        .tag_wr_set     (tag_wr_set),
        .tag_wr_way     (tag_wr_way),
        .tag_wr_tag     (tag_wr_tag),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_way       (resp_way)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural cache model: contents, valid flags, RR pointer, PLRU tree (heap-indexed)
    bit          mvalid [32][8];
    logic [19:0] mtag   [32][8];
    int          mptr   [32];
    bit          mtree  [32][7];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 32; s++) begin
            mptr[s] = 0;
            for (int w = 0; w < 8; w++) mvalid[s][w] = 1'b0;
            for (int n = 0; n < 7; n++) mtree[s][n] = 1'b0;
        end
    endtask

    function automatic int find_hit(input int s, input logic [19:0] t);
        for (int w = 0; w < 8; w++)
            if (mvalid[s][w] && mtag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic bit model_full(input int s);
        for (int w = 0; w < 8; w++)
            if (!mvalid[s][w]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_vbits(input int s);
        logic [31:0] v = 0;
        for (int w = 0; w < 8; w++) v[w] = mvalid[s][w];
        return v;
    endfunction

    // Point every node on the accessed way's path away from it (node n has children 2n+1, 2n+2)
    task automatic model_touch(input int s, input int w);
        int n = 0;
        for (int lv = 2; lv >= 0; lv--) begin
            int b = (w >> lv) & 1;
            mtree[s][n] = (b == 0);
            n = 2 * n + 1 + b;
        end
    endtask

    function automatic int model_victim(input int s);
        for (int w = 0; w < 8; w++)
            if (!mvalid[s][w]) return w;
`ifdef REF_CACHE_PLRU_EN
        begin
            int n = 0;
            int v = 0;
            for (int lv = 0; lv < 3; lv++) begin
                int b = mtree[s][n];
                v = 2 * v + b;
                n = 2 * n + 1 + b;
            end
            return v;
        end
`else
        return mptr[s];
`endif
    endfunction

    // One lookup, called at a negedge with lkp_valid low; returns at a negedge in IDLE
    task automatic do_lookup(input int s, input logic [19:0] t, input int k, input int d,
                             input bit inv_in_wait);
        int hw;
        int vw;
        int waited = 0;
        while (!lkp_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("lkp_ready_idle", lkp_ready, 1);
        hw          = find_hit(s, t);
        lkp_valid   = 1'b1;
        lkp_set     = 5'(s);
        lkp_tag     = t;
        cmp_ishit   = (hw >= 0);
        cmp_set_idx = (hw >= 0) ? 3'(hw) : 3'($urandom_range(0, 7));
        #1;
        chk("valid_bits_out", valid_bits_out, model_vbits(s));
        if (hw >= 0) begin
            @(negedge clk);
            lkp_valid = 1'b0;
            chk("hit_resp_valid", resp_valid, 1);
            chk("hit_resp_hit", resp_hit, 1);
            chk("hit_resp_way", resp_way, hw);
            model_touch(s, hw);
            return;
        end
        vw = model_victim(s);
        @(negedge clk);
        lkp_valid = 1'b0;
        cmp_ishit = 1'b0;
        for (int i = 0; i <= k; i++) begin
            if (i > 0) @(negedge clk);
            chk("fill_req_valid", fill_req_valid, 1);
            chk("fill_req_set", fill_req_set, s);
            chk("fill_req_way", fill_req_way, vw);
            chk("fill_req_tag", fill_req_tag, t);
            chk("no_resp_in_req", resp_valid, 0);
            chk("lkp_ready_busy", lkp_ready, 0);
            fill_req_ready = (i == k);
        end
        for (int j = 0; j <= d; j++) begin
            @(negedge clk);
            fill_req_ready = 1'b0;
            chk("fill_req_dropped", fill_req_valid, 0);
            chk("no_tag_wr_in_wait", tag_wr_en, 0);
            chk("no_resp_in_wait", resp_valid, 0);
            inv_all   = inv_in_wait && (j == 0);
            fill_done = (j == d);
        end
        @(negedge clk);
        fill_done = 1'b0;
        inv_all   = 1'b0;
        chk("tag_wr_en", tag_wr_en, 1);
        chk("tag_wr_set", tag_wr_set, s);
        chk("tag_wr_way", tag_wr_way, vw);
        chk("tag_wr_tag", tag_wr_tag, t);
        chk("miss_resp_valid", resp_valid, 1);
        chk("miss_resp_hit", resp_hit, 0);
        chk("miss_resp_way", resp_way, vw);
        if (model_full(s)) mptr[s] = (mptr[s] + 1) % 8;
        mvalid[s][vw] = 1'b1;
        mtag[s][vw]   = t;
        model_touch(s, vw);
        if (inv_in_wait) begin
            @(negedge clk);
            #1;
            chk("inv_valid_cleared", valid_bits_out, 0);
            chk("inv_lkp_ready_low", lkp_ready, 0);
            model_clear();
        end
        @(negedge clk);
        chk("idle_no_resp", resp_valid, 0);
        chk("idle_no_tag_wr", tag_wr_en, 0);
    endtask

    // Back-to-back hits on valid ways of a set: one response per cycle, one cycle after accept
    task automatic hit_burst(input int s);
        int ways [4] = '{1, 5, 2, 7};
        for (int i = 0; i < 4; i++) begin
            chk("burst_lkp_ready", lkp_ready, 1);
            if (i > 0) begin
                chk("burst_resp_valid", resp_valid, 1);
                chk("burst_resp_hit", resp_hit, 1);
                chk("burst_resp_way", resp_way, ways[i-1]);
            end
            lkp_valid   = 1'b1;
            lkp_set     = 5'(s);
            lkp_tag     = mtag[s][ways[i]];
            cmp_ishit   = 1'b1;
            cmp_set_idx = 3'(ways[i]);
            model_touch(s, ways[i]);
            @(negedge clk);
        end
        lkp_valid = 1'b0;
        cmp_ishit = 1'b0;
        chk("burst_resp_valid", resp_valid, 1);
        chk("burst_resp_way", resp_way, ways[3]);
        @(negedge clk);
        chk("burst_resp_end", resp_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; lkp_valid = 1'b0; lkp_set = '0; lkp_tag = '0;
        cmp_ishit = 1'b0; cmp_set_idx = '0; inv_all = 1'b0;
        fill_req_ready = 1'b0; fill_done = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_fill_req_valid", fill_req_valid, 0);
        chk("rst_tag_wr_en", tag_wr_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_lkp_ready", lkp_ready, 0);
        chk("rst_valid_bits", valid_bits_out, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_lkp_ready", lkp_ready, 1);

        // First miss into an empty set goes to way 0
        do_lookup(3, 20'h12345, 0, 2, 1'b0);
        lkp_set = 5'd3;
        #1;
        chk("set3_way0_valid", valid_bits_out, 8'h01);

        // fill_done outside FILL_WAIT must do nothing
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        chk("stray_done_no_resp", resp_valid, 0);
        chk("stray_done_no_wr", tag_wr_en, 0);

        // Fill the rest of set 3; way 1 stalls on fill_req_ready for 5 cycles
        do_lookup(3, 20'h20001, 5, 1, 1'b0);
        for (int i = 2; i < 8; i++) do_lookup(3, 20'h20000 + 20'(i), i % 3, i % 2, 1'b0);

        // Hits on ways 0 and 4, then two misses into the full set
        do_lookup(3, 20'h12345, 0, 0, 1'b0);
        do_lookup(3, 20'h20004, 0, 0, 1'b0);
        do_lookup(3, 20'h00AAA, 0, 0, 1'b0);
        do_lookup(3, 20'h00BBB, 1, 0, 1'b0);

        hit_burst(3);

        // Invalidate while a fill is outstanding
        do_lookup(4, 20'h0CAFE, 0, 2, 1'b1);
        lkp_set = 5'd3;
        #1;
        chk("inv_set3_cleared", valid_bits_out, 0);

        // Randomized traffic over a few sets with a small tag pool to mix hits and evictions
        for (int n = 0; n < 150; n++) begin
            do_lookup($urandom_range(0, 3), 20'h30000 + 20'($urandom_range(0, 11)),
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        // Reset during FILL_WAIT aborts the miss
        do_lookup(5, 20'h5A5A5, 0, 0, 1'b0);
        lkp_valid = 1'b1; lkp_set = 5'd6; lkp_tag = 20'h77777; cmp_ishit = 1'b0;
        @(negedge clk);
        lkp_valid = 1'b0;
        chk("rst_mid_req", fill_req_valid, 1);
        fill_req_ready = 1'b1;
        @(negedge clk);
        fill_req_ready = 1'b0;
        reset = 1'b1;
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        chk("rst_mid_tag_wr", tag_wr_en, 0);
        chk("rst_mid_resp", resp_valid, 0);
        chk("rst_mid_fill_req", fill_req_valid, 0);
        chk("rst_mid_fill_fields", {fill_req_set, fill_req_way, fill_req_tag}, 0);
        chk("rst_mid_resp_way", resp_way, 0);
        chk("rst_mid_lkp_ready", lkp_ready, 0);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_mid_ready_back", lkp_ready, 1);
        lkp_set = 5'd5;
        #1;
        chk("rst_mid_valid_clear", valid_bits_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
